// File: rtl/flash_pkg.sv
// flash_pkg: shared definitions for the NOR flash programming slave.
// Holds bus-cycle phase encoding, sequencer states, AMD command bytes,
// default x8 unlock addresses and a helper that picks the next byte lane.
// Optional feature macro used by the design: FLASH_PROG_ERASE_EN.
package flash_pkg;

  localparam int unsigned FLASH_AW_DEF = 22;

  localparam logic [21:0] UNLOCK1_DEF = 22'hAAA;
  localparam logic [21:0] UNLOCK2_DEF = 22'h555;

  localparam logic [7:0] CMD_AA = 8'hAA;
  localparam logic [7:0] CMD_55 = 8'h55;
  localparam logic [7:0] CMD_A0 = 8'hA0;
  localparam logic [7:0] CMD_80 = 8'h80;
  localparam logic [7:0] CMD_30 = 8'h30;
  localparam logic [7:0] CMD_F0 = 8'hF0;

  // Flash pin phases; ST_NEXT/ST_ACK are the sequencer's between-byte and acknowledge steps.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD_SETUP = 3'd1,
    ST_CMD_WE    = 3'd2,
    ST_CMD_HOLD  = 3'd3,
    ST_POLL_RD   = 3'd4,
    ST_POLL_CHK  = 3'd5,
    ST_NEXT      = 3'd6,
    ST_ACK       = 3'd7
  } state_e;

  // Top sequencer: SEQ_RUN covers every phase owned by the bus-cycle engine.
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_NEXT = 2'd2,
    SEQ_ACK  = 2'd3
  } seq_e;

  // Lowest pending byte offset: {valid, offset}. Bit i of pend is byte offset i.
  function automatic logic [2:0] first_pending(input logic [3:0] pend);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// flash_bus_cycle: one timed flash bus cycle, write or poll read.
// Write: SETUP (1 clk) -> WE low (ws clks) -> HOLD (1 clk).
// Read : OE low (ws clks) -> CHK (1 clk, OE high, data compared by caller).
// Ports: clk_i/rst_i (sync active-high); start_i/rd_i/adr_i/dat_i launch a cycle;
//        done_o is high during HOLD/CHK, where start_i chains the next cycle with
//        no idle clock; flash_*_o are the registered pin values.
module flash_bus_cycle
  import flash_pkg::*;
#(
  parameter int unsigned aw = FLASH_AW_DEF,
  parameter int unsigned ws = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          rd_i,
  input  logic [aw-1:0] adr_i,
  input  logic [7:0]    dat_i,
  output logic          done_o,
  output logic          flash_ce_o,
  output logic          flash_oe_o,
  output logic          flash_we_o,
  output logic          flash_dat_oe_o,
  output logic [aw-1:0] flash_adr_o,
  output logic [7:0]    flash_dat_o
);

  localparam int unsigned CNT_W = (ws > 1) ? $clog2(ws) : 1;

  state_e           phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             ce_q, oe_q, we_q, dat_oe_q;
  logic [aw-1:0]    adr_q;
  logic [7:0]       dat_q;

  // Phase sequencing and pin registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      dat_oe_q <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (phase_q)
        ST_CMD_SETUP: begin
          phase_q <= ST_CMD_WE;
          we_q    <= 1'b0;
          cnt_q   <= CNT_W'(ws - 1);
        end
        ST_CMD_WE: begin
          if (cnt_q == '0) begin
            phase_q <= ST_CMD_HOLD;
            we_q    <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_POLL_RD: begin
          if (cnt_q == '0) begin
            phase_q <= ST_POLL_CHK;
            oe_q    <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          // IDLE, HOLD and CHK may launch the next cycle back to back; CE stays low.
          if (start_i) begin
            ce_q  <= 1'b0;
            we_q  <= 1'b1;
            adr_q <= adr_i;
            dat_q <= dat_i;
            cnt_q <= CNT_W'(ws - 1);
            if (rd_i) begin
              phase_q  <= ST_POLL_RD;
              oe_q     <= 1'b0;
              dat_oe_q <= 1'b0;
            end else begin
              phase_q  <= ST_CMD_SETUP;
              oe_q     <= 1'b1;
              dat_oe_q <= 1'b1;
            end
          end else begin
            phase_q  <= ST_IDLE;
            ce_q     <= 1'b1;
            oe_q     <= 1'b1;
            we_q     <= 1'b1;
            dat_oe_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign done_o         = done_q;
  assign flash_ce_o     = ce_q;
  assign flash_oe_o     = oe_q;
  assign flash_we_o     = we_q;
  assign flash_dat_oe_o = dat_oe_q;
  assign flash_adr_o    = adr_q;
  assign flash_dat_o    = dat_q;

endmodule

// File: rtl/flash_prog.sv
// flash_prog: Wishbone slave that programs a byte-wide AMD-style NOR flash.
// A 32-bit write becomes one unlock/program/DQ7-poll sequence per selected byte
// (offset 0..3, big-endian). A read returns {31'b0, err} and clears err.
// Poll timeout sets err, issues F0 @ 0 and abandons the remaining bytes.
// Optional macro FLASH_PROG_ERASE_EN: a write with wb_adr_i[22]=1 erases the
// sector at wb_adr_i[aw-1:0] instead of programming.
// Ports: wb_* Wishbone slave (sync active-high wb_rst_i); flash_* device pins,
//        flash_dat_oe tells the top level to drive flash_dat_o; flash_rst = !wb_rst_i.
module flash_prog
  import flash_pkg::*;
#(
  parameter int unsigned    aw       = FLASH_AW_DEF,
  parameter int unsigned    ws       = 5,
  parameter logic [aw-1:0]  unlock1  = aw'(UNLOCK1_DEF),
  parameter logic [aw-1:0]  unlock2  = aw'(UNLOCK2_DEF),
  parameter logic [15:0]    poll_max = 16'hFFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [31:0] flash_adr_o,
  output logic [7:0]  flash_dat_o,
  input  logic [7:0]  flash_dat_i,
  output logic        flash_dat_oe,
  output logic        flash_ce,
  output logic        flash_oe,
  output logic        flash_we,
  output logic        flash_rst
);

  localparam int unsigned PCNT_W = 24;

  seq_e              state_q;
  logic [2:0]        step_q;
  logic [1:0]        off_q;
  logic [3:0]        pend_q;
  logic [aw-1:0]     adr_q;
  logic [31:0]       dat_q;
  logic              erase_q;
  logic              f0_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic              err_q;
  logic              ack_q;
  logic [31:0]       rdat_q;

  logic              wb_acc_c;
  logic              erase_req_c;
  logic [3:0]        sel_off_c;
  logic [2:0]        first_sel_c;
  logic [2:0]        next_sel_c;
  logic [7:0]        byte_dat_c;
  logic [aw-1:0]     byte_adr_c;
  logic [2:0]        poll_step_c;
  logic [PCNT_W-1:0] limit_c;
  logic              match_c;
  logic              timeout_c;
  logic              start_c;
  logic [2:0]        launch_step_c;
  logic              launch_f0_c;
  logic              cmd_rd_c;
  logic [aw-1:0]     cmd_adr_c;
  logic [7:0]        cmd_dat_c;
  logic              bc_done;
  logic [aw-1:0]     bc_adr;
  logic              unused_c;

  assign wb_acc_c = wb_cyc_i & wb_stb_i;

`ifdef FLASH_PROG_ERASE_EN
  assign erase_req_c = wb_adr_i[22];
`else
  assign erase_req_c = 1'b0;
`endif

  // Byte lanes reordered so bit i is byte offset i (sel[3] is offset 0).
  assign sel_off_c   = {wb_sel_i[0], wb_sel_i[1], wb_sel_i[2], wb_sel_i[3]};
  assign first_sel_c = first_pending(sel_off_c);
  assign next_sel_c  = first_pending(pend_q);

  always_comb begin
    byte_dat_c = dat_q[31:24];
    case (off_q)
      2'd1:    byte_dat_c = dat_q[23:16];
      2'd2:    byte_dat_c = dat_q[15:8];
      2'd3:    byte_dat_c = dat_q[7:0];
      default: byte_dat_c = dat_q[31:24];
    endcase
  end

  assign byte_adr_c  = {adr_q[aw-1:2], off_q};
  assign poll_step_c = erase_q ? 3'd6 : 3'd4;
  assign limit_c     = erase_q ? {poll_max, 8'h00} : {8'h00, poll_max};
  // Erase completes when DQ7 reads 1; program completes when DQ7 equals the programmed bit.
  assign match_c     = flash_dat_i[7] == (erase_q ? 1'b1 : byte_dat_c[7]);
  assign timeout_c   = (pcnt_q + PCNT_W'(1)) == limit_c;

  // Decide which command the bus engine launches this cycle.
  always_comb begin
    start_c       = 1'b0;
    launch_step_c = 3'd0;
    launch_f0_c   = 1'b0;
    case (state_q)
      SEQ_IDLE: start_c = wb_acc_c & wb_we_i & (erase_req_c | first_sel_c[2]);
      SEQ_NEXT: start_c = next_sel_c[2];
      SEQ_RUN: begin
        if (bc_done && !f0_q) begin
          if (step_q != poll_step_c) begin
            start_c       = 1'b1;
            launch_step_c = step_q + 3'd1;
          end else if (!match_c) begin
            start_c       = 1'b1;
            launch_step_c = step_q;
            launch_f0_c   = timeout_c;
          end
        end
      end
      default: start_c = 1'b0;
    endcase
  end

  // Command table; step 0 is AA @ unlock1 for both program and erase.
  always_comb begin
    cmd_rd_c  = 1'b0;
    cmd_adr_c = unlock1;
    cmd_dat_c = CMD_AA;
    if (launch_f0_c) begin
      cmd_adr_c = '0;
      cmd_dat_c = CMD_F0;
    end else if (erase_q) begin
      case (launch_step_c)
        3'd1:    begin cmd_adr_c = unlock2; cmd_dat_c = CMD_55; end
        3'd2:    begin cmd_adr_c = unlock1; cmd_dat_c = CMD_80; end
        3'd3:    begin cmd_adr_c = unlock1; cmd_dat_c = CMD_AA; end
        3'd4:    begin cmd_adr_c = unlock2; cmd_dat_c = CMD_55; end
        3'd5:    begin cmd_adr_c = adr_q;   cmd_dat_c = CMD_30; end
        3'd6:    begin cmd_adr_c = adr_q;   cmd_rd_c  = 1'b1;   end
        default: begin cmd_adr_c = unlock1; cmd_dat_c = CMD_AA; end
      endcase
    end else begin
      case (launch_step_c)
        3'd1:    begin cmd_adr_c = unlock2;    cmd_dat_c = CMD_55;     end
        3'd2:    begin cmd_adr_c = unlock1;    cmd_dat_c = CMD_A0;     end
        3'd3:    begin cmd_adr_c = byte_adr_c; cmd_dat_c = byte_dat_c; end
        3'd4:    begin cmd_adr_c = byte_adr_c; cmd_rd_c  = 1'b1;       end
        default: begin cmd_adr_c = unlock1;    cmd_dat_c = CMD_AA;     end
      endcase
    end
  end

  // Sequencer: accepts accesses only in IDLE, walks bytes, counts polls, acks.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= SEQ_IDLE;
      step_q  <= '0;
      off_q   <= '0;
      pend_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      erase_q <= 1'b0;
      f0_q    <= 1'b0;
      pcnt_q  <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (wb_acc_c) begin
            if (!wb_we_i) begin
              ack_q   <= 1'b1;
              rdat_q  <= {31'b0, err_q};
              err_q   <= 1'b0;
              state_q <= SEQ_ACK;
            end else begin
              adr_q   <= wb_adr_i[aw-1:0];
              dat_q   <= wb_dat_i;
              erase_q <= erase_req_c;
              f0_q    <= 1'b0;
              step_q  <= '0;
              pcnt_q  <= '0;
              if (erase_req_c) begin
                pend_q  <= '0;
                state_q <= SEQ_RUN;
              end else if (first_sel_c[2]) begin
                off_q   <= first_sel_c[1:0];
                pend_q  <= sel_off_c & ~(4'b0001 << first_sel_c[1:0]);
                state_q <= SEQ_RUN;
              end else begin
                ack_q   <= 1'b1;
                state_q <= SEQ_ACK;
              end
            end
          end
        end
        SEQ_RUN: begin
          if (bc_done) begin
            if (f0_q) begin
              ack_q   <= wb_acc_c;
              state_q <= SEQ_ACK;
            end else if (step_q != poll_step_c) begin
              step_q <= launch_step_c;
            end else if (match_c) begin
              state_q <= SEQ_NEXT;
            end else if (timeout_c) begin
              err_q <= 1'b1;
              f0_q  <= 1'b1;
            end else begin
              pcnt_q <= pcnt_q + PCNT_W'(1);
            end
          end
        end
        SEQ_NEXT: begin
          step_q <= '0;
          pcnt_q <= '0;
          if (next_sel_c[2]) begin
            off_q   <= next_sel_c[1:0];
            pend_q  <= pend_q & ~(4'b0001 << next_sel_c[1:0]);
            state_q <= SEQ_RUN;
          end else begin
            // Master may have abandoned the cycle; the flash work still finished.
            ack_q   <= wb_acc_c;
            state_q <= SEQ_ACK;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= SEQ_IDLE;
        end
      endcase
    end
  end

  flash_bus_cycle #(
    .aw (aw),
    .ws (ws)
  ) u_bus (
    .clk_i          (wb_clk_i),
    .rst_i          (wb_rst_i),
    .start_i        (start_c),
    .rd_i           (cmd_rd_c),
    .adr_i          (cmd_adr_c),
    .dat_i          (cmd_dat_c),
    .done_o         (bc_done),
    .flash_ce_o     (flash_ce),
    .flash_oe_o     (flash_oe),
    .flash_we_o     (flash_we),
    .flash_dat_oe_o (flash_dat_oe),
    .flash_adr_o    (bc_adr),
    .flash_dat_o    (flash_dat_o)
  );

  assign flash_adr_o = {{(32 - aw){1'b0}}, bc_adr};
  assign flash_rst   = ~wb_rst_i;
  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = rdat_q;

  assign unused_c = ^wb_adr_i[31:aw];

endmodule

// File: tb/tb_flash_prog.sv
// tb_flash_prog: directed bench for flash_prog with a small NOR flash model
// that logs command writes and answers DQ7 polls (optionally wrong N times).
module tb_flash_prog;

  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;
  logic [31:0] f_adr;
  logic [7:0]  f_dat_o, f_dat_i;
  logic        f_dat_oe, f_ce, f_oe, f_we, f_rst;

  int n_checks = 0;
  int n_fail   = 0;

  // Flash model state.
  logic [31:0] wlog[$];
  logic [7:0]  last_dat = 8'h00;
  int          bad_left = 0;
  bit          never_ok = 1'b0;
  bit          erase_mode = 1'b0;
  int          polls = 0;
  int          acks = 0;
  logic        we_prev = 1'b1;
  logic        oe_prev = 1'b1;

  always #5 clk = ~clk;

  flash_prog #(
    .aw       (22),
    .ws       (5),
    .poll_max (16'd8)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb_adr_i     (wb_adr),
    .wb_dat_i     (wb_dat_w),
    .wb_dat_o     (wb_dat_r),
    .wb_sel_i     (wb_sel),
    .wb_we_i      (wb_we),
    .wb_stb_i     (wb_stb),
    .wb_cyc_i     (wb_cyc),
    .wb_ack_o     (wb_ack),
    .flash_adr_o  (f_adr),
    .flash_dat_o  (f_dat_o),
    .flash_dat_i  (f_dat_i),
    .flash_dat_oe (f_dat_oe),
    .flash_ce     (f_ce),
    .flash_oe     (f_oe),
    .flash_we     (f_we),
    .flash_rst    (f_rst)
  );

  // Model: log a write on WE rising with CE low; answer each poll read on OE falling.
  always @(negedge clk) begin
    logic resp;
    if (!f_ce && f_we && !we_prev) begin
      wlog.push_back({f_adr[23:0], f_dat_o});
      last_dat = f_dat_o;
    end
    if (!f_ce && !f_oe && oe_prev) begin
      polls++;
      resp = erase_mode ? 1'b1 : last_dat[7];
      if (never_ok || bad_left > 0) begin
        resp = ~resp;
        if (bad_left > 0) bad_left--;
      end
      f_dat_i = {resp, 7'h2A};
    end
    we_prev = f_we;
    oe_prev = f_oe;
    if (wb_ack) acks++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, output int cyc_n, output logic [31:0] rdat);
    wb_adr = adr; wb_dat_w = dat; wb_sel = sel; wb_we = we;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    cyc_n = 0;
    while (cyc_n < BUDGET) begin
      @(posedge clk); #1;
      cyc_n++;
      if (wb_ack) break;
    end
    rdat = wb_dat_r;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
  endtask

  // Expected program sequence for one byte, packed as {adr[23:0], data}.
  task automatic check_prog(input string tag, input int base, input logic [23:0] badr, input logic [7:0] bdat);
    logic [31:0] exp[4];
    exp[0] = {24'hAAA, 8'hAA};
    exp[1] = {24'h555, 8'h55};
    exp[2] = {24'hAAA, 8'hA0};
    exp[3] = {badr, bdat};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_w%0d", tag, k), (base + k < wlog.size()) ? wlog[base + k] : 32'hxxxxxxxx, exp[k]);
    end
  endtask

  initial begin
    int          cyc_n;
    int          a0;
    int          wait_n;
    logic [31:0] rd;
    logic [7:0]  bytes[4];

    f_dat_i = 8'h00;
    rst = 1'b1;
    wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, wb_ack}, 32'd0);
    check("rst_dat", wb_dat_r, 32'd0);
    check("rst_pins", {28'b0, f_ce, f_oe, f_we, f_dat_oe}, 32'hE);
    check("rst_adr", f_adr, 32'd0);
    check("rst_fdat", {24'b0, f_dat_o}, 32'd0);
    check("rst_frst", {31'b0, f_rst}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("frst_rel", {31'b0, f_rst}, 32'd1);

    // Full word program, all polls succeed first time.
    wlog.delete(); polls = 0; a0 = acks;
    wb_xfer(32'h100, 32'hDEADBEEF, 4'hF, 1'b1, cyc_n, rd);
    check("w4_cycles", 32'(cyc_n), 32'd141);
    check("w4_nwr", 32'(wlog.size()), 32'd16);
    bytes[0] = 8'hDE; bytes[1] = 8'hAD; bytes[2] = 8'hBE; bytes[3] = 8'hEF;
    for (int b = 0; b < 4; b++) check_prog($sformatf("w4_b%0d", b), 4 * b, 24'(32'h100 + b), bytes[b]);
    check("w4_polls", 32'(polls), 32'd4);
    check("w4_acks", 32'(acks - a0), 32'd1);
    wb_xfer(32'h0, 32'h0, 4'hF, 1'b0, cyc_n, rd);
    check("w4_rd", rd, 32'd0);
    check("rd_cycles", 32'(cyc_n), 32'd1);

    // Sparse byte enables: offsets 1 and 3 only.
    wlog.delete(); polls = 0; a0 = acks;
    wb_xfer(32'h200, 32'h11223344, 4'b0101, 1'b1, cyc_n, rd);
    check("sp_cycles", 32'(cyc_n), 32'd71);
    check("sp_nwr", 32'(wlog.size()), 32'd8);
    check_prog("sp_b1", 0, 24'h201, 8'h22);
    check_prog("sp_b3", 4, 24'h203, 8'h44);
    check("sp_acks", 32'(acks - a0), 32'd1);

    // No byte enables: immediate ack, flash untouched.
    wlog.delete(); polls = 0; a0 = acks;
    wb_xfer(32'h240, 32'hFFFFFFFF, 4'b0000, 1'b1, cyc_n, rd);
    check("s0_cycles", 32'(cyc_n), 32'd1);
    check("s0_nwr", 32'(wlog.size()), 32'd0);
    check("s0_acks", 32'(acks - a0), 32'd1);

    // DQ7 wrong for three polls.
    wlog.delete(); polls = 0; bad_left = 3;
    wb_xfer(32'h300, 32'h80000000, 4'b1000, 1'b1, cyc_n, rd);
    check("slow_cycles", 32'(cyc_n), 32'd54);
    check("slow_polls", 32'(polls), 32'd4);
    check_prog("slow", 0, 24'h300, 8'h80);
    wb_xfer(32'h0, 32'h0, 4'hF, 1'b0, cyc_n, rd);
    check("slow_err", rd, 32'd0);

    // Never completes: timeout after 8 polls, F0 @ 0, remaining bytes skipped.
    wlog.delete(); polls = 0; never_ok = 1'b1; a0 = acks;
    wb_xfer(32'h400, 32'h12345678, 4'hF, 1'b1, cyc_n, rd);
    never_ok = 1'b0;
    check("to_cycles", 32'(cyc_n), 32'd84);
    check("to_polls", 32'(polls), 32'd8);
    check("to_nwr", 32'(wlog.size()), 32'd5);
    check_prog("to_b0", 0, 24'h400, 8'h12);
    check("to_f0", (wlog.size() > 4) ? wlog[4] : 32'hxxxxxxxx, {24'h0, 8'hF0});
    check("to_acks", 32'(acks - a0), 32'd1);
    wb_xfer(32'h0, 32'h0, 4'hF, 1'b0, cyc_n, rd);
    check("to_rd1", rd, 32'd1);
    wb_xfer(32'h0, 32'h0, 4'hF, 1'b0, cyc_n, rd);
    check("to_rd2", rd, 32'd0);

    // Reset while WE is low.
    wlog.delete(); a0 = acks;
    wb_adr = 32'h500; wb_dat_w = 32'hA5A5A5A5; wb_sel = 4'hF; wb_we = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    wait_n = 0;
    while (f_we !== 1'b0 && wait_n < 100) begin @(posedge clk); #1; wait_n++; end
    check("rs_reach_we", {31'b0, f_we}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rs_pins", {29'b0, f_ce, f_we, f_rst}, 32'b110);
    check("rs_ack", {31'b0, wb_ack}, 32'd0);
    rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("rs_noack", 32'(acks - a0), 32'd0);
    check("rs_nwr", 32'(wlog.size()), 32'd0);
    wlog.delete(); polls = 0;
    wb_xfer(32'h600, 32'h00C30000, 4'b0010, 1'b1, cyc_n, rd);
    check("rs_after_cycles", 32'(cyc_n), 32'd36);
    check_prog("rs_after", 0, 24'h602, 8'h00);

    // Master drops the cycle during polling.
    wlog.delete(); polls = 0; bad_left = 2; a0 = acks;
    wb_adr = 32'h700; wb_dat_w = 32'h9A000000; wb_sel = 4'b1000; wb_we = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    wait_n = 0;
    while (f_oe !== 1'b0 && wait_n < 100) begin @(posedge clk); #1; wait_n++; end
    check("dr_reach_poll", {31'b0, f_oe}, 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("dr_noack", 32'(acks - a0), 32'd0);
    check("dr_polls", 32'(polls), 32'd3);
    check_prog("dr", 0, 24'h700, 8'h9A);
    wb_xfer(32'h0, 32'h0, 4'hF, 1'b0, cyc_n, rd);
    check("dr_rd_cycles", 32'(cyc_n), 32'd1);
    check("dr_rd", rd, 32'd0);

`ifdef FLASH_PROG_ERASE_EN
    // Sector erase: six command writes, poll for DQ7=1, one ack.
    wlog.delete(); polls = 0; erase_mode = 1'b1; a0 = acks;
    wb_xfer(32'h400100, 32'h0, 4'h0, 1'b1, cyc_n, rd);
    erase_mode = 1'b0;
    check("er_cycles", 32'(cyc_n), 32'd50);
    check("er_nwr", 32'(wlog.size()), 32'd6);
    check("er_w2", (wlog.size() > 2) ? wlog[2] : 32'hxxxxxxxx, {24'hAAA, 8'h80});
    check("er_w5", (wlog.size() > 5) ? wlog[5] : 32'hxxxxxxxx, {24'h100, 8'h30});
    check("er_polls", 32'(polls), 32'd1);
    check("er_acks", 32'(acks - a0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_prog.md
Name: flash_prog

Overview:
Wishbone slave that programs the byte-wide parallel NOR flash. It is the write-side counterpart of the existing flash read port.
- Each 32-bit Wishbone write is split into per-byte AMD-style program command sequences.
- Completion of each byte is detected by DQ7 data polling.
- A sticky error flag is readable over the same slave port.
- Sits on the Wishbone bus beside the flash read slave; both share the flash pins through top-level muxing.

Parameters:
aw, 22, flash byte-address bits used from wb_adr_i
ws, 5, clocks flash_we (or flash_oe during polling) is held low per flash bus cycle
unlock1, 22'hAAA, first unlock address (x8 mode)
unlock2, 22'h555, second unlock address (x8 mode)
poll_max, 16'hFFFF, maximum DQ7 polls per byte before timeout

Ports:
wb_clk_i  in  1  clock; all logic on rising edge
wb_rst_i  in  1  synchronous active-high reset
wb_adr_i  in  32  byte address; [aw-1:2] word select; [22] erase flag (see Optional Feature)
wb_dat_i  in  32  write data, big-endian: [31:24] to byte offset 0
wb_dat_o  out  32  read data {31'b0, err}
wb_sel_i  in  4  byte enables; sel[3] = offset 0 … sel[0] = offset 3
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  one-cycle acknowledge
flash_adr_o  out  32  flash byte address, upper bits zero
flash_dat_o  out  8  data driven to flash
flash_dat_i  in  8  data from flash
flash_dat_oe  out  1  1 = top level drives flash_dat_o onto the pins
flash_ce  out  1  chip enable, active low
flash_oe  out  1  output enable, active low
flash_we  out  1  write enable, active low
flash_rst  out  1  = !wb_rst_i

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, err=0, flash_ce=flash_oe=flash_we=1, flash_dat_oe=0, flash_adr_o=0, flash_dat_o=0, state=IDLE.
- Reset mid-operation: return to IDLE on the next edge; no ack is issued. flash_rst resets the device.
- Read access (wb_acc & !we): ack 1 cycle after the access is seen in IDLE; wb_dat_o={31'b0,err}. The read clears err on the same edge as the ack.
- Write with wb_sel_i==0: ack 1 cycle after acceptance; no flash activity.
- Write otherwise: latch address, data and sel in IDLE. Process selected bytes in order offset 0..3, skipping unselected bytes.
- Byte program sequence, four flash write cycles:
  - AA @ unlock1
  - 55 @ unlock2
  - A0 @ unlock1
  - data @ {word,offset}
- Flash write cycle, ws+2 clocks:
  - CMD_SETUP (1 clk): ce=0, adr/dat valid, dat_oe=1
  - CMD_WE (ws clks): we=0
  - CMD_HOLD (1 clk): we=1, adr/dat still held
- Polling, after the data cycle:
  - POLL_RD (ws clks): ce=0, oe=0, dat_oe=0, adr = byte address
  - POLL_CHK (1 clk): oe=1; compare flash_dat_i[7] with programmed data[7]
  - Match: the byte is done.
  - Mismatch: count++ and repeat POLL_RD.
- Timeout: count reaching poll_max sets err. Issue one write cycle F0 @ 0 (reset to read mode), skip the remaining bytes, then ack.
- States: IDLE, CMD_SETUP, CMD_WE, CMD_HOLD, POLL_RD, POLL_CHK, NEXT, ACK.
  - NEXT selects the next byte or ACK.
  - ACK drives wb_ack_o=1 for exactly one cycle, then IDLE.
- ce=1 in IDLE, NEXT and ACK. ce=0 continuously inside a flash cycle.
- Master drops cyc/stb mid-sequence: the sequence still runs to completion (flash must not be interrupted). ACK state suppresses wb_ack_o if wb_acc is now 0.
- New accesses are not sampled until the block has returned to IDLE.
- Timing example: 4-byte program with immediate poll success = 4×(4×(ws+2)+ws+1)+NEXT/ACK overhead. With ws=5: 4×34 + 5 = 141 clocks.

Optional Feature:
Macro FLASH_PROG_ERASE_EN.
- Defined: a write with wb_adr_i[22]=1 erases the sector containing wb_adr_i[aw-1:0], ignoring data and sel.
  - Sequence: AA@unlock1, 55@unlock2, 80@unlock1, AA@unlock1, 55@unlock2, 30@sector address.
  - Then poll until DQ7=1, with timeout at poll_max×256 polls.
  - One ack at completion.
- Not defined: bit 22 is ignored and the access is a normal program.

Decomposition:
- Shared package flash_pkg:
  - state encoding localparams
  - command bytes CMD_AA, CMD_55, CMD_A0, CMD_80, CMD_30, CMD_F0
  - default unlock addresses
- Sub-module flash_bus_cycle: performs one timed flash write or read cycle (setup/strobe/hold, ws parameter) with start/done handshake. The top FSM sequences the commands.

Test Plan:
- Write 0xDEADBEEF, sel=F, adr 0x100, model polls OK first try → flash sees 16 command writes in order; bytes DE,AD,BE,EF written at 0x100..0x103; single ack; read returns 0.
- Write sel=4'b0101, data 0x11223344 → only 0x22@+1 and 0x44@+3 programmed; one ack.
- Flash model holds DQ7 inverted for 3 polls → 4 POLL_RD cycles for that byte, then completes; err stays 0.
- Model never completes, poll_max=8 → err=1, F0@0 issued, remaining bytes skipped, ack. First read returns 1; second read returns 0.
- Assert wb_rst_i during CMD_WE → next cycle ce=we=1, flash_rst=0, no ack. Next write completes normally.
- Drop cyc during polling → sequence finishes, no ack. With FLASH_PROG_ERASE_EN, write adr 0x400100 → 6-cycle erase sequence, 30@0x100, polls, one ack.
